// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing block: ALUop codes,
// FSM state encoding and the round-robin pick helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // One-hot grant; on contention the requester not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
        logic [1:0] gnt;
        if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
        else              gnt = req;
        return gnt;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. Grants only while enabled,
// so the one-hot output can drive the request readys directly.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       en,
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) gnt = rr_pick(req, last_grant);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Optional ALU_FLAGS_EN adds registered rsp_zero / rsp_neg result flags.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
`ifdef ALU_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_neg,
`endif
    output logic             busy
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [1:0]       gnt;

    rr_arb2 u_arb (
        .en         (state_q == IDLE),
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_q),
        .gnt        (gnt)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (|gnt) begin
                owner_d = gnt[1];
                last_d  = gnt[1];
                a_d     = gnt[1] ? req1_a  : req0_a;
                b_d     = gnt[1] ? req1_b  : req0_b;
                op_d    = gnt[1] ? req1_op : req0_op;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = alu_result;
                state_d  = RESP;
            end
            RESP: if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic zero_q, zero_d, neg_q, neg_d;

    // Flags are captured on the same edge as result_q so they track it exactly.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (state_q == EXEC) begin
            zero_d = (alu_result == '0);
            neg_d  = alu_result[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign rsp_zero = zero_q;
    assign rsp_neg  = neg_q;
`endif

    assign req0_ready  = gnt[0];
    assign req1_ready  = gnt[1];
    assign rsp0_valid  = (state_q == RESP) && !owner_q;
    assign rsp1_valid  = (state_q == RESP) &&  owner_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign busy        = (state_q != IDLE);

endmodule
